// File: rtl/pc_redirect_ctrl.sv
// Fetch-PC sequencer (BOOT/RUN/RECOVER): pc_o registered, one-cycle next-PC update; redirects restart fetch after a bubble.
// stall_i holds the PC in RUN only; flush/stall outputs are combinational, everything else is registered.
module pc_redirect_ctrl #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned BOOT_CYCLES    = 2,
  parameter int unsigned RECOVER_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_i,
  input  logic        pred_taken_i,
  input  logic [31:0] pred_pc_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        is_ctrl_s2_i,
  output logic [31:0] pc_o,
  output logic        pc_valid_o,
  output logic        flush_if_o,
  output logic        flush_id_o,
  output logic        stall_if_o,
  output logic [1:0]  state_o,
  output logic [15:0] ctrl_cnt_o,
  output logic [15:0] mispred_cnt_o
);

  typedef enum logic [1:0] {
    ST_BOOT    = 2'b00,
    ST_RUN     = 2'b01,
    ST_RECOVER = 2'b10
  } state_t;

  localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};
  localparam logic [3:0]  BOOT_LD     = 4'(BOOT_CYCLES);
  localparam logic [3:0]  RECOVER_LD  = 4'(RECOVER_CYCLES);

  state_t      state;
  logic [3:0]  cnt;
  logic        active;
  logic        take_redirect;
  logic [31:0] redirect_al;
  logic [31:0] pred_al;
  logic        unused_low_bits;

  // Fetch is word aligned; the low target bits carry no information.
  assign redirect_al     = {redirect_pc_i[31:2], 2'b00};
  assign pred_al         = {pred_pc_i[31:2], 2'b00};
  assign unused_low_bits = ^{redirect_pc_i[1:0], pred_pc_i[1:0]};

  // Reset forces BOOT asynchronously, so these are already low while rst_ni is low.
  assign active        = (state == ST_RUN) || (state == ST_RECOVER);
  assign take_redirect = redirect_i && active;
  assign flush_if_o    = take_redirect;
  assign flush_id_o    = take_redirect;
  assign stall_if_o    = stall_i && (state == ST_RUN) && !redirect_i;
  assign state_o       = state;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= ST_BOOT;
      pc_o          <= RESET_PC_AL;
      pc_valid_o    <= 1'b0;
      cnt           <= BOOT_LD;
      ctrl_cnt_o    <= 16'h0000;
      mispred_cnt_o <= 16'h0000;
    end else begin
      if (is_ctrl_s2_i && active && (ctrl_cnt_o != 16'hFFFF))
        ctrl_cnt_o <= ctrl_cnt_o + 16'd1;
      if (take_redirect && (mispred_cnt_o != 16'hFFFF))
        mispred_cnt_o <= mispred_cnt_o + 16'd1;

      case (state)
        ST_BOOT: begin
          if (cnt <= 4'd1) begin
            state      <= ST_RUN;
            pc_valid_o <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RUN: begin
          if (redirect_i) begin
            pc_o       <= redirect_al;
            state      <= ST_RECOVER;
            cnt        <= RECOVER_LD;
            pc_valid_o <= 1'b0;
          end else if (!stall_i) begin
            // A prediction seen under stall is dropped; stage 0 presents it again.
            if (pred_taken_i) pc_o <= pred_al;
            else              pc_o <= pc_o + 32'd4;
          end
        end
        ST_RECOVER: begin
          if (redirect_i) begin
            pc_o <= redirect_al;
            cnt  <= RECOVER_LD;
          end else if (cnt <= 4'd1) begin
            // pc_o already holds the target, so the first RUN fetch is the target.
            state      <= ST_RUN;
            pc_valid_o <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state      <= ST_BOOT;
          pc_o       <= RESET_PC_AL;
          pc_valid_o <= 1'b0;
          cnt        <= BOOT_LD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Scoreboard bench for pc_redirect_ctrl: expected fetch PCs are queued as stimulus is driven, popped on pc_valid_o.
module tb_pc_redirect_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall = 1'b0, pt = 1'b0, rd = 1'b0, isc = 1'b0;
  logic [31:0] ppc = 32'h0, rpc = 32'h0;
  logic [31:0] pc_o;
  logic        pc_valid_o, flush_if_o, flush_id_o, stall_if_o;
  logic [1:0]  state_o;
  logic [15:0] ctrl_cnt_o, mispred_cnt_o;

  int          checks = 0;
  int          passed = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;

  always #5 clk = ~clk;

  pc_redirect_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n), .stall_i(stall), .pred_taken_i(pt), .pred_pc_i(ppc),
    .redirect_i(rd), .redirect_pc_i(rpc), .is_ctrl_s2_i(isc),
    .pc_o(pc_o), .pc_valid_o(pc_valid_o), .flush_if_o(flush_if_o), .flush_id_o(flush_id_o),
    .stall_if_o(stall_if_o), .state_o(state_o), .ctrl_cnt_o(ctrl_cnt_o), .mispred_cnt_o(mispred_cnt_o)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_in(input logic s, input logic p, input logic [31:0] pp,
                        input logic r, input logic [31:0] rp, input logic c);
    stall = s; pt = p; ppc = pp; rd = r; rpc = rp; isc = c;
  endtask

  task automatic do_reset();
    exp_q.delete();
    set_in(0, 0, 32'h0, 0, 32'h0, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    exp_q.delete();
    set_in(1, 1, 32'h40, 1, 32'h80, 1);
    #1 rst_n = 1'b0;
    #1;
    checks++; if (state_o !== 2'b00) $display("FAIL rst_state: got %b exp 00", state_o); else passed++;
    checks++; if (pc_o !== 32'h0) $display("FAIL rst_pc: got %h exp 00000000", pc_o); else passed++;
    checks++; if (pc_valid_o !== 1'b0) $display("FAIL rst_valid: got %b exp 0", pc_valid_o); else passed++;
    checks++; if (ctrl_cnt_o !== 16'h0) $display("FAIL rst_ctrl: got %h exp 0000", ctrl_cnt_o); else passed++;
    checks++; if (mispred_cnt_o !== 16'h0) $display("FAIL rst_mis: got %h exp 0000", mispred_cnt_o); else passed++;
    checks++; if ({flush_if_o, flush_id_o, stall_if_o} !== 3'b000)
      $display("FAIL rst_flush_stall: got %b exp 000", {flush_if_o, flush_id_o, stall_if_o}); else passed++;
    tick();
    tick();
    checks++; if (state_o !== 2'b00 || pc_o !== 32'h0) $display("FAIL rst_hold: got %b/%h exp 00/00000000", state_o, pc_o); else passed++;
    set_in(0, 0, 32'h0, 0, 32'h0, 1);
    rst_n = 1'b1;
    #1;
    checks++; if (pc_valid_o !== 1'b0) $display("FAIL boot_valid0: got %b exp 0", pc_valid_o); else passed++;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8); exp_q.push_back(32'hC);
    for (int i = 0; i < 5; i++) begin
      if (i == 0) set_in(0, 0, 32'h0, 0, 32'h0, 1);
      else if (i == 1) begin
        set_in(0, 0, 32'h0, 1, 32'h500, 1);
        #1;
        checks++; if (flush_if_o !== 1'b0) $display("FAIL boot_redirect_flush: got %b exp 0", flush_if_o); else passed++;
      end else set_in(0, 0, 32'h0, 0, 32'h0, 0);
      tick();
      if (i == 0) begin
        checks++; if (pc_valid_o !== 1'b0) $display("FAIL boot_valid1: got %b exp 0", pc_valid_o); else passed++;
      end
      if (pc_valid_o) begin
        checks++;
        if (exp_q.size() == 0) $display("FAIL boot_fetch: unexpected pc %h", pc_o);
        else begin e = exp_q.pop_front(); if (pc_o !== e) $display("FAIL boot_fetch: got %h exp %h", pc_o, e); else passed++; end
      end
    end
    checks++; if (exp_q.size() != 0) $display("FAIL boot_missing: %0d fetches not seen exp 0", exp_q.size()); else passed++;
    checks++; if (ctrl_cnt_o !== 16'h0 || mispred_cnt_o !== 16'h0)
      $display("FAIL boot_counts: got %h/%h exp 0000/0000", ctrl_cnt_o, mispred_cnt_o); else passed++;
  endtask

  task automatic test_predict_redirect();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: begin set_in(0, 1, 32'h40, 0, 32'h0, 0); exp_q.push_back(32'h40); end
        1: begin set_in(0, 1, 32'h100, 0, 32'h0, 0); exp_q.push_back(32'h100); end
        2: begin set_in(0, 0, 32'h0, 1, 32'h44, 1); exp_q.push_back(32'h44); end
        3: set_in(0, 0, 32'h0, 0, 32'h0, 1);
        default: begin set_in(0, 0, 32'h0, 0, 32'h0, 0); exp_q.push_back(32'h48); end
      endcase
      if (i == 2) begin
        #1;
        checks++; if ({flush_if_o, flush_id_o} !== 2'b11) $display("FAIL redir_flush: got %b exp 11", {flush_if_o, flush_id_o}); else passed++;
      end
      tick();
      if (i == 2) begin
        checks++; if (pc_valid_o !== 1'b0 || state_o !== 2'b10)
          $display("FAIL redir_bubble: got valid %b state %b exp 0/10", pc_valid_o, state_o); else passed++;
      end
      if (pc_valid_o) begin
        checks++;
        if (exp_q.size() == 0) $display("FAIL redir_fetch: unexpected pc %h", pc_o);
        else begin e = exp_q.pop_front(); if (pc_o !== e) $display("FAIL redir_fetch: got %h exp %h", pc_o, e); else passed++; end
      end
    end
    checks++; if (exp_q.size() != 0) $display("FAIL redir_missing: %0d fetches not seen exp 0", exp_q.size()); else passed++;
    checks++; if (mispred_cnt_o !== 16'd1) $display("FAIL redir_mis: got %h exp 0001", mispred_cnt_o); else passed++;
    checks++; if (ctrl_cnt_o !== 16'd2) $display("FAIL redir_ctrl: got %h exp 0002", ctrl_cnt_o); else passed++;
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: begin set_in(0, 1, 32'h20, 0, 32'h0, 0); exp_q.push_back(32'h20); end
        1: begin set_in(1, 1, 32'h300, 0, 32'h0, 0); exp_q.push_back(32'h20); end
        2, 3: begin set_in(1, 0, 32'h0, 0, 32'h0, 0); exp_q.push_back(32'h20); end
        4: begin set_in(1, 0, 32'h0, 1, 32'h60, 0); exp_q.push_back(32'h60); end
        5: set_in(1, 0, 32'h0, 0, 32'h0, 0);
        default: begin set_in(0, 0, 32'h0, 0, 32'h0, 0); exp_q.push_back(32'h64); end
      endcase
      #1;
      if (i >= 1 && i <= 3) begin
        checks++; if (stall_if_o !== 1'b1) $display("FAIL stall_if_%0d: got %b exp 1", i, stall_if_o); else passed++;
      end
      if (i == 4) begin
        checks++; if ({stall_if_o, flush_if_o, flush_id_o} !== 3'b011)
          $display("FAIL stall_redirect: got %b exp 011", {stall_if_o, flush_if_o, flush_id_o}); else passed++;
      end
      if (i == 5) begin
        checks++; if (stall_if_o !== 1'b0) $display("FAIL stall_recover: got %b exp 0", stall_if_o); else passed++;
      end
      tick();
      if (i == 4) begin
        checks++; if (pc_valid_o !== 1'b0 || pc_o !== 32'h60)
          $display("FAIL stall_target: got %b/%h exp 0/00000060", pc_valid_o, pc_o); else passed++;
      end
      if (pc_valid_o) begin
        checks++;
        if (exp_q.size() == 0) $display("FAIL stall_fetch: unexpected pc %h", pc_o);
        else begin e = exp_q.pop_front(); if (pc_o !== e) $display("FAIL stall_fetch: got %h exp %h", pc_o, e); else passed++; end
      end
    end
    checks++; if (exp_q.size() != 0) $display("FAIL stall_missing: %0d fetches not seen exp 0", exp_q.size()); else passed++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: set_in(0, 0, 32'h0, 1, 32'h80, 0);
        1: begin set_in(0, 0, 32'h0, 1, 32'h90, 0); exp_q.push_back(32'h90); end
        2: set_in(0, 0, 32'h0, 0, 32'h0, 0);
        default: begin set_in(0, 0, 32'h0, 0, 32'h0, 0); exp_q.push_back(32'h94); end
      endcase
      if (i < 2) begin
        #1;
        checks++; if (flush_if_o !== 1'b1) $display("FAIL b2b_flush_%0d: got %b exp 1", i, flush_if_o); else passed++;
      end
      tick();
      if (i == 1) begin
        checks++; if (state_o !== 2'b10 || pc_o !== 32'h90)
          $display("FAIL b2b_reload: got %b/%h exp 10/00000090", state_o, pc_o); else passed++;
      end
      if (i == 2) begin
        checks++; if (state_o !== 2'b01) $display("FAIL b2b_run: got %b exp 01", state_o); else passed++;
      end
      if (pc_valid_o) begin
        checks++;
        if (exp_q.size() == 0) $display("FAIL b2b_fetch: unexpected pc %h", pc_o);
        else begin e = exp_q.pop_front(); if (pc_o !== e) $display("FAIL b2b_fetch: got %h exp %h", pc_o, e); else passed++; end
      end
    end
    checks++; if (exp_q.size() != 0) $display("FAIL b2b_missing: %0d fetches not seen exp 0", exp_q.size()); else passed++;
    checks++; if (mispred_cnt_o !== 16'd2) $display("FAIL b2b_mis: got %h exp 0002", mispred_cnt_o); else passed++;
  endtask

  task automatic test_wrap_align();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: begin set_in(0, 1, 32'hFFFF_FFFC, 0, 32'h0, 0); exp_q.push_back(32'hFFFF_FFFC); end
        1: begin set_in(0, 0, 32'h0, 0, 32'h0, 0); exp_q.push_back(32'h0); end
        2: begin set_in(0, 0, 32'h0, 1, 32'h0000_0107, 0); exp_q.push_back(32'h0000_0104); end
        3: set_in(0, 0, 32'h0, 0, 32'h0, 0);
        default: begin set_in(0, 1, 32'h0000_0203, 0, 32'h0, 0); exp_q.push_back(32'h0000_0200); end
      endcase
      tick();
      if (i == 2) begin
        checks++; if (pc_o !== 32'h0000_0104) $display("FAIL wrap_align: got %h exp 00000104", pc_o); else passed++;
      end
      if (pc_valid_o) begin
        checks++;
        if (exp_q.size() == 0) $display("FAIL wrap_fetch: unexpected pc %h", pc_o);
        else begin e = exp_q.pop_front(); if (pc_o !== e) $display("FAIL wrap_fetch: got %h exp %h", pc_o, e); else passed++; end
      end
    end
    checks++; if (exp_q.size() != 0) $display("FAIL wrap_missing: %0d fetches not seen exp 0", exp_q.size()); else passed++;
  endtask

  task automatic test_saturate_reset();
    do_reset();
    set_in(0, 0, 32'h0, 1, 32'h1000, 1);
    repeat (65534) tick();
    checks++; if (mispred_cnt_o !== 16'hFFFE) $display("FAIL sat_mis_fffe: got %h exp fffe", mispred_cnt_o); else passed++;
    checks++; if (ctrl_cnt_o !== 16'hFFFE) $display("FAIL sat_ctrl_fffe: got %h exp fffe", ctrl_cnt_o); else passed++;
    tick();
    tick();
    checks++; if (mispred_cnt_o !== 16'hFFFF) $display("FAIL sat_mis: got %h exp ffff", mispred_cnt_o); else passed++;
    checks++; if (ctrl_cnt_o !== 16'hFFFF) $display("FAIL sat_ctrl: got %h exp ffff", ctrl_cnt_o); else passed++;
    checks++; if (state_o !== 2'b10) $display("FAIL sat_state: got %b exp 10", state_o); else passed++;
    set_in(1, 0, 32'h0, 1, 32'h2000, 1);
    rst_n = 1'b0;
    #1;
    checks++; if (pc_o !== 32'h0 || state_o !== 2'b00 || pc_valid_o !== 1'b0)
      $display("FAIL midrec_rst: got %h/%b/%b exp 00000000/00/0", pc_o, state_o, pc_valid_o); else passed++;
    checks++; if (ctrl_cnt_o !== 16'h0 || mispred_cnt_o !== 16'h0)
      $display("FAIL midrec_cnts: got %h/%h exp 0000/0000", ctrl_cnt_o, mispred_cnt_o); else passed++;
    checks++; if ({flush_if_o, flush_id_o, stall_if_o} !== 3'b000)
      $display("FAIL midrec_flush: got %b exp 000", {flush_if_o, flush_id_o, stall_if_o}); else passed++;
    set_in(0, 0, 32'h0, 0, 32'h0, 0);
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (pc_valid_o !== 1'b0) $display("FAIL reboot_valid0: got %b exp 0", pc_valid_o); else passed++;
    tick();
    checks++; if (pc_valid_o !== 1'b1 || pc_o !== 32'h0)
      $display("FAIL reboot_fetch: got %b/%h exp 1/00000000", pc_valid_o, pc_o); else passed++;
  endtask

  initial begin
    test_reset();
    test_predict_redirect();
    test_stall();
    test_back_to_back();
    test_wrap_align();
    test_saturate_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
